// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one read at a time on the instruction bus,
// presents the returned word to decode, and handles flushes and bus timeouts.
module if_fetch #(
    parameter logic [31:0] RESET_INST = 32'h0000_0013,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        id_ready,
    output logic        stall,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        inst_valid,
    output logic        fetch_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t        state, state_d;
    logic          drop, drop_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          timed_out;
    logic          ibus_req_d;
    logic [31:0]   ibus_addr_d;
    logic [31:0]   inst_d;
    logic [31:0]   inst_addr_d;
    logic          inst_valid_d;
    logic          fetch_err_d;

    // Saturating wait counter and the cycle on which the wait gives up.
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign timed_out = !ibus_rvalid && (cnt == CNT_LAST);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            drop       <= 1'b0;
            cnt        <= '0;
            ibus_req   <= 1'b0;
            ibus_addr  <= '0;
            inst       <= RESET_INST;
            inst_addr  <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_d;
            drop       <= drop_d;
            cnt        <= cnt_d;
            ibus_req   <= ibus_req_d;
            ibus_addr  <= ibus_addr_d;
            inst       <= inst_d;
            inst_addr  <= inst_addr_d;
            inst_valid <= inst_valid_d;
            fetch_err  <= fetch_err_d;
        end
    end

    // Next-state, next-output and PC-generator hold logic.
    always_comb begin
        state_d      = state;
        drop_d       = drop;
        cnt_d        = cnt;
        ibus_addr_d  = ibus_addr;
        inst_d       = inst;
        inst_addr_d  = inst_addr;
        inst_valid_d = inst_valid;
        fetch_err_d  = fetch_err;

        case (state)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (ibus_gnt) begin
                    // A flush before or with the grant turns this read into a drain.
                    state_d = (drop || flush) ? S_DRAIN : S_WAIT;
                    cnt_d   = '0;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (ibus_rvalid) begin
                    if (flush) begin
                        state_d = S_REQ;
                    end else begin
                        inst_d       = ibus_rdata;
                        inst_addr_d  = ibus_addr;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (timed_out) begin
                    fetch_err_d = 1'b1;
                    drop_d      = 1'b0;
                    state_d     = S_REQ;
                end else if (flush) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HOLD: begin
                if (id_ready || flush) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_DRAIN: begin
                if (ibus_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end else if (timed_out) begin
                    fetch_err_d = 1'b1;
                    drop_d      = 1'b0;
                    state_d     = S_REQ;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ibus_req_d = (state_d == S_REQ);
        // Address is captured once on REQ entry and held until the grant.
        if ((state_d == S_REQ) && (state != S_REQ)) begin
            ibus_addr_d = pc;
        end

        stall = rst || !(((state == S_HOLD) && id_ready) || flush);
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_INST, default 32'h0000_0013, is the instruction value driven on inst during and after reset.
REQ-002 Parameter TIMEOUT, default 255, is the maximum number of cycles spent waiting for ibus_rvalid before an error is flagged.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pc  in  32  fetch address from the PC generator.
REQ-006 flush  in  1  jump taken; discards the in-flight fetch.
REQ-007 id_ready  in  1  decode stage accepts inst this cycle.
REQ-008 stall  out  1  drives the PC generator's nop input; 1 = hold pc.
REQ-009 ibus_req  out  1  instruction bus read request.
REQ-010 ibus_addr  out  32  instruction bus read address.
REQ-011 ibus_gnt  in  1  bus accepts request this cycle.
REQ-012 ibus_rvalid  in  1  read data valid.
REQ-013 ibus_rdata  in  32  read data.
REQ-014 inst  out  32  fetched instruction.
REQ-015 inst_addr  out  32  address of inst.
REQ-016 inst_valid  out  1  inst/inst_addr valid for decode.
REQ-017 fetch_err  out  1  sticky bus timeout flag.

Function
REQ-018 The FSM shall have the states IDLE, REQ, WAIT, HOLD and DRAIN, plus a 1-bit drop flag.
REQ-019 IDLE shall move to REQ unconditionally on the next cycle.
REQ-020 On entry to REQ, pc shall be latched into ibus_addr, and ibus_req=1 shall hold throughout REQ.
REQ-021 ibus_addr shall be held stable while ibus_req=1 and ibus_gnt=0.
REQ-022 In REQ, ibus_gnt=1 shall move to WAIT, or to DRAIN if drop=1; ibus_req=0 from the next cycle.
REQ-023 In WAIT, ibus_rvalid=1 shall register ibus_rdata into inst and ibus_addr into inst_addr, set inst_valid, and move to HOLD.
REQ-024 Minimum latency: gnt in the same cycle as req plus rvalid one cycle later gives inst_valid=1 two cycles after ibus_req first rises.
REQ-025 In HOLD, inst_valid=1; id_ready=1 completes the handshake, clears inst_valid next cycle and moves to REQ.
REQ-026 stall shall be 0 only in (HOLD and id_ready=1) or when flush=1; otherwise 1.
REQ-027 stall and flush shall never both be 1 in a cycle (the PC generator requires this).
REQ-028 flush in HOLD shall clear inst_valid next cycle and move to REQ.
REQ-029 flush in WAIT without rvalid shall move to DRAIN.
REQ-030 flush in WAIT with rvalid the same cycle shall discard the data and move to REQ.
REQ-031 flush in REQ with gnt=1 shall move to DRAIN.
REQ-032 flush in REQ with gnt=0 shall set drop, stay in REQ and keep ibus_addr unchanged.
REQ-033 flush in IDLE or DRAIN shall have no effect beyond stall=0.
REQ-034 DRAIN shall wait for ibus_rvalid, discard the data, clear drop and move to REQ; the new pc shall be latched on REQ entry.
REQ-035 A flush during a REQ that was entered with drop=1 shall keep drop=1.
REQ-036 The timeout counter shall clear on entry to WAIT or DRAIN, increment each cycle without rvalid, and saturate.
REQ-037 When the counter reaches TIMEOUT: set fetch_err (sticky), clear drop, move to REQ and reissue from the current pc.
REQ-038 inst and inst_addr shall change only on an accepted (non-discarded) rvalid.

Reset
REQ-039 While rst=1, outputs shall be forced asynchronously to: state=IDLE, drop=0, counter=0, ibus_req=0, ibus_addr=0, inst=RESET_INST, inst_addr=0, inst_valid=0, stall=1, fetch_err=0.
REQ-040 Reset mid-transaction shall abandon any outstanding bus read, with no completion tracking after release.
REQ-041 The first request shall issue 2 cycles after rst deasserts (IDLE, then REQ).

Verification
REQ-042 Zero-wait fetch: pc=0x100, gnt=1 at req, rvalid next cycle with rdata=0x00500093, id_ready=1 -> inst=0x00500093, inst_addr=0x100, stall low one cycle, next req addr=0x104.
REQ-043 Backpressure: id_ready=0 for 3 cycles in HOLD -> inst_valid stays 1, inst stable, stall=1, no new ibus_req.
REQ-044 Flush in WAIT: req 0x200 granted, flush with jump to 0x400 before rvalid -> rdata discarded, inst_valid stays 0, next req addr=0x400.
REQ-045 Flush in REQ, gnt late: flush while gnt=0, gnt 2 cycles later -> addr unchanged until gnt, response dropped, then req at new pc.
REQ-046 Timeout: TIMEOUT=4, no rvalid -> fetch_err=1 after 4 WAIT cycles, req reissued, fetch_err stays 1 until rst.
REQ-047 Async reset in HOLD -> inst_valid=0, inst=0x00000013 immediately, no clock required.
